key_event_decoder: RTL

Consumes the debounced single-cycle press (high-to-low) and release (low-to-high) pulses produced by the key debounce stage. Classifies each gesture as a short press, a double click, or a long press with auto-repeat, and emits one-cycle event pulses. Sits between the debouncer and application logic such as menu, counter or mode control.

---
 rtl/key_event_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced key pulses into short, double, long and repeat events
module key_event_decoder #(
  parameter int CLKS_PER_MS = 100000,
  parameter int LONG_MS     = 1000,
  parameter int DOUBLE_MS   = 250,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic press_in,
  input  logic release_in,
  output logic short_out,
  output logic double_out,
  output logic long_out,
  output logic repeat_out,
  output logic held_out
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [15:0]   LONG_T    = 16'(LONG_MS);
  localparam logic [15:0]   DOUBLE_T  = 16'(DOUBLE_MS);
  localparam logic [15:0]   REPEAT_T  = 16'(REPEAT_MS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic          short_q, double_q, long_q, repeat_q, held_q;
  logic          short_d, double_d, long_d, repeat_d, held_d;
  logic          restart;
  logic          tick;
  logic          press_only;
  logic          release_only;

  // Coincident press and release cancel each other out.
  assign press_only   = press_in & ~release_in;
  assign release_only = release_in & ~press_in;
  assign tick         = (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    restart  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_only) state_d = PRESS1;
      end
      PRESS1: begin
        if (release_only) begin
          state_d = WAIT2;
        end else if (ms_cnt_q == LONG_T) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
        end
      end
      LONG_HOLD: begin
        if (release_only) begin
          state_d = IDLE;
        end else if (ms_cnt_q == REPEAT_T) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_only) begin
          state_d = PRESS2;
        end else if (ms_cnt_q == DOUBLE_T) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (release_only) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) restart = 1'b1;
  end

  always_comb begin
    presc_d  = presc_q;
    ms_cnt_d = ms_cnt_q;
    if (restart) begin
      presc_d  = '0;
      ms_cnt_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (ms_cnt_q != 16'hFFFF) ms_cnt_d = ms_cnt_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  assign held_d = (state_d == PRESS1) || (state_d == LONG_HOLD) || (state_d == PRESS2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      ms_cnt_q <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign short_out  = short_q;
  assign double_out = double_q;
  assign long_out   = long_q;
  assign repeat_out = repeat_q;
  assign held_out   = held_q;

endmodule
